// File: rtl/ram_1r1w_byte_mask_pipe_pkg.sv
// Shared helpers for the lane-masked 1R1W RAM: parameter legality checks and
// the per-lane merge used when a same-cycle write is forwarded to a read.
package ram_1r1w_byte_mask_pipe_pkg;

  localparam int RAM_MAX_W     = 1024;
  localparam int RAM_MAX_LANES = 128;

  function automatic bit ram_width_ok(input int data_w, input int byte_w);
    return (byte_w > 0) && (data_w > 0) && (data_w <= RAM_MAX_W) &&
           (data_w % byte_w == 0) && (data_w / byte_w <= RAM_MAX_LANES);
  endfunction

  function automatic bit ram_lat_ok(input int rd_lat);
    return (rd_lat == 1) || (rd_lat == 2);
  endfunction

  // Lanes selected by mask take new_w, the rest keep old_w.
  function automatic logic [RAM_MAX_W-1:0] ram_lane_merge(
    input logic [RAM_MAX_W-1:0]     old_w,
    input logic [RAM_MAX_W-1:0]     new_w,
    input logic [RAM_MAX_LANES-1:0] mask,
    input int                       byte_w
  );
    logic [RAM_MAX_W-1:0] m;
    m = old_w;
    for (int i = 0; i < RAM_MAX_W; i++) begin
      if ((i / byte_w) < RAM_MAX_LANES && mask[i / byte_w]) m[i] = new_w[i];
    end
    return m;
  endfunction

endpackage

// File: rtl/ram_1r1w_byte_mask_pipe_if.sv
// Bus bundle for the lane-masked 1R1W RAM: write port plus read request/response streams.
// Handshakes: a transfer happens on a clock edge where val & rdy are both 1; a
// producer holding val may not retract it, and rdy never depends combinationally on val.
interface ram_1r1w_byte_mask_pipe_if #(
  parameter int DATA_W = 64,
  parameter int MASK_W = 8,
  parameter int ADDR_W = 9
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [MASK_W-1:0] wr_mask;
  logic              rd_req_val;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_req_rdy;
  logic              rd_resp_val;
  logic [DATA_W-1:0] rd_resp_data;
  logic              rd_resp_rdy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_mask, rd_req_val, rd_req_addr, rd_resp_rdy,
    input  rd_req_rdy, rd_resp_val, rd_resp_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_mask, rd_req_val, rd_req_addr, rd_resp_rdy,
    output rd_req_rdy, rd_resp_val, rd_resp_data
  );
endinterface

// File: rtl/ram_1r1w_byte_mask_pipe_resp_fifo.sv
// First-word-fall-through response FIFO; a push into an empty FIFO is visible
// on rd_data in the same cycle and can be popped straight through.
module ram_1r1w_byte_mask_pipe_resp_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_val,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_val,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_rdy
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic             empty, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign rd_val  = !empty || wr_val;
  assign rd_data = empty ? wr_data : mem[rptr];
  // Pass-through (empty, push and pop together) never touches storage.
  assign push    = wr_val && !(empty && rd_rdy);
  assign pop     = !empty && rd_rdy;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count == CNT_W'(DEPTH)));
endmodule

// File: rtl/ram_1r1w_byte_mask_pipe.sv
// Simple-dual-port lane-masked RAM with a credit-controlled, lossless read stream.
// Define RAM_1R1W_BYTE_MASK_PIPE_BYPASS_EN to forward same-cycle same-address writes per lane.
module ram_1r1w_byte_mask_pipe
  import ram_1r1w_byte_mask_pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int BYTE_W = 8,
  parameter int DEPTH  = 512,
  parameter int RD_LAT = 1
) (
  input logic                      clk,
  input logic                      rst_n,
  ram_1r1w_byte_mask_pipe_if.slave bus
);
  localparam int MASK_W   = DATA_W / BYTE_W;
  localparam int CRED_MAX = RD_LAT + 1;
  localparam int CRED_W   = $clog2(CRED_MAX + 1);

  if (!ram_width_ok(DATA_W, BYTE_W)) begin : g_bad_width
    $error("DATA_W must be a multiple of BYTE_W");
  end
  if (!ram_lat_ok(RD_LAT)) begin : g_bad_lat
    $error("RD_LAT must be 1 or 2");
  end

  logic [CRED_W-1:0] credits;
  logic              req_rdy, rd_accept, resp_val, resp_hs;
  logic              rd_val1, pipe_val;
  logic [DATA_W-1:0] rd_old, rd_src, rd_word, pipe_data;

  assign req_rdy        = (credits != '0);
  assign bus.rd_req_rdy = req_rdy;
  assign rd_accept      = bus.rd_req_val && req_rdy;
  assign resp_hs        = resp_val && bus.rd_resp_rdy;

  // One narrow array per lane so masked writes map onto plain block-RAM write enables.
  for (genvar i = 0; i < MASK_W; i++) begin : g_lane
    logic [BYTE_W-1:0] lane_mem [DEPTH];
    always_ff @(posedge clk) begin
      if (bus.wr_en && bus.wr_mask[i]) lane_mem[bus.wr_addr] <= bus.wr_data[i*BYTE_W +: BYTE_W];
    end
    assign rd_old[i*BYTE_W +: BYTE_W] = lane_mem[bus.rd_req_addr];
  end

`ifdef RAM_1R1W_BYTE_MASK_PIPE_BYPASS_EN
  logic fwd_hit;
  assign fwd_hit = bus.wr_en && (bus.wr_addr == bus.rd_req_addr);
  assign rd_src  = fwd_hit ? DATA_W'(ram_lane_merge(RAM_MAX_W'(rd_old), RAM_MAX_W'(bus.wr_data),
                                                    RAM_MAX_LANES'(bus.wr_mask), BYTE_W))
                           : rd_old;
`else
  assign rd_src = rd_old;
`endif

  always_ff @(posedge clk) begin
    if (rd_accept) rd_word <= rd_src;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_val1 <= 1'b0;
    else        rd_val1 <= rd_accept;
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              rd_val2;
    logic [DATA_W-1:0] rd_word2;
    always_ff @(posedge clk) begin
      if (rd_val1) rd_word2 <= rd_word;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_val2 <= 1'b0;
      else        rd_val2 <= rd_val1;
    end
    assign pipe_val  = rd_val2;
    assign pipe_data = rd_word2;
  end else begin : g_lat1
    assign pipe_val  = rd_val1;
    assign pipe_data = rd_word;
  end

  ram_1r1w_byte_mask_pipe_resp_fifo #(.WIDTH(DATA_W), .DEPTH(CRED_MAX)) u_resp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_val  (pipe_val),
    .wr_data (pipe_data),
    .rd_val  (resp_val),
    .rd_data (bus.rd_resp_data),
    .rd_rdy  (bus.rd_resp_rdy)
  );
  assign bus.rd_resp_val = resp_val;

  // Credits count free response slots: in-flight reads plus buffered responses never exceed CRED_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      credits <= CRED_W'(CRED_MAX);
    else if (rd_accept && !resp_hs)  credits <= credits - CRED_W'(1);
    else if (resp_hs && !rd_accept)  credits <= credits + CRED_W'(1);
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(rd_accept && credits == '0));
  assert property (@(posedge clk) disable iff (!rst_n)
    !(resp_hs && !rd_accept && credits == CRED_W'(CRED_MAX)));
endmodule

// File: tb/tb_ram_1r1w_byte_mask_pipe.sv
// Bench for ram_1r1w_byte_mask_pipe: RD_LAT=1 and RD_LAT=2 instances share one stimulus stream
// and are each checked every cycle against a queue-based model of the read stream.
module tb_ram_1r1w_byte_mask_pipe;
  localparam int DATA_W = 128;
  localparam int BYTE_W = 16;
  localparam int MASK_W = DATA_W / BYTE_W;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [MASK_W-1:0] wr_mask = '0;
  logic              rd_req_val = 1'b0;
  logic [ADDR_W-1:0] rd_req_addr = '0;
  logic              rd_resp_rdy = 1'b0;

  ram_1r1w_byte_mask_pipe_if #(.DATA_W(DATA_W), .MASK_W(MASK_W), .ADDR_W(ADDR_W)) bus1 ();
  ram_1r1w_byte_mask_pipe_if #(.DATA_W(DATA_W), .MASK_W(MASK_W), .ADDR_W(ADDR_W)) bus2 ();

  assign bus1.wr_en = wr_en;           assign bus2.wr_en = wr_en;
  assign bus1.wr_addr = wr_addr;       assign bus2.wr_addr = wr_addr;
  assign bus1.wr_data = wr_data;       assign bus2.wr_data = wr_data;
  assign bus1.wr_mask = wr_mask;       assign bus2.wr_mask = wr_mask;
  assign bus1.rd_req_val = rd_req_val; assign bus2.rd_req_val = rd_req_val;
  assign bus1.rd_req_addr = rd_req_addr; assign bus2.rd_req_addr = rd_req_addr;
  assign bus1.rd_resp_rdy = rd_resp_rdy; assign bus2.rd_resp_rdy = rd_resp_rdy;

  ram_1r1w_byte_mask_pipe #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .DEPTH(DEPTH), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  ram_1r1w_byte_mask_pipe #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .DEPTH(DEPTH), .RD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  logic              rdy_o  [2];
  logic              val_o  [2];
  logic [DATA_W-1:0] data_o [2];
  assign rdy_o[0] = bus1.rd_req_rdy;  assign rdy_o[1] = bus2.rd_req_rdy;
  assign val_o[0] = bus1.rd_resp_val; assign val_o[1] = bus2.rd_resp_val;
  assign data_o[0] = bus1.rd_resp_data; assign data_o[1] = bus2.rd_resp_data;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] exp_q [2][$];
  int                due_q [2][$];
  int                acc_cnt [2];
  int                resp_cnt [2];
  logic [DATA_W-1:0] last_resp [2];
  int                first_cyc [2];
  int                last_cyc [2];
  int                rdy_low_cnt [2];
  logic              in_t3 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] init_word(input int a);
    return {4{32'hC0DE_0000 | 32'(a)}};
  endfunction

  // Spec-level model: a read accepted in cycle c is due in cycle c+lat; the
  // stream may hold at most lat+1 outstanding reads; responses leave in order.
  task automatic model_step(input int k);
    int lat;
    logic exp_rdy, exp_val;
    logic [DATA_W-1:0] rd;
    lat = k + 1;
    if (!rst_n) begin
      exp_q[k].delete();
      due_q[k].delete();
      check($sformatf("rst_rdy_l%0d", lat), DATA_W'(rdy_o[k]), DATA_W'(1));
      check($sformatf("rst_val_l%0d", lat), DATA_W'(val_o[k]), DATA_W'(0));
      return;
    end
    exp_rdy = (exp_q[k].size() < lat + 1);
    exp_val = (exp_q[k].size() != 0) && (due_q[k][0] <= cyc);
    check($sformatf("req_rdy_l%0d", lat), DATA_W'(rdy_o[k]), DATA_W'(exp_rdy));
    check($sformatf("resp_val_l%0d", lat), DATA_W'(val_o[k]), DATA_W'(exp_val));
    if (exp_val && val_o[k])
      check($sformatf("resp_data_l%0d", lat), data_o[k], exp_q[k][0]);
    if (rdy_o[k] && rd_req_val) acc_cnt[k]++;
    if (val_o[k] && rd_resp_rdy) begin
      resp_cnt[k]++;
      last_resp[k] = data_o[k];
      if (first_cyc[k] < 0) first_cyc[k] = cyc;
      last_cyc[k] = cyc;
    end
    if (in_t3 && !rdy_o[k]) rdy_low_cnt[k]++;
    if (exp_rdy && rd_req_val) begin
      rd = model_mem[rd_req_addr];
`ifdef RAM_1R1W_BYTE_MASK_PIPE_BYPASS_EN
      if (wr_en && wr_addr == rd_req_addr)
        for (int b = 0; b < MASK_W; b++)
          if (wr_mask[b]) rd[b*BYTE_W +: BYTE_W] = wr_data[b*BYTE_W +: BYTE_W];
`endif
      exp_q[k].push_back(rd);
      due_q[k].push_back(cyc + lat);
    end
    if (exp_val && rd_resp_rdy) begin
      void'(exp_q[k].pop_front());
      void'(due_q[k].pop_front());
    end
  endtask

  // Compare process: inputs and outputs are stable at the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
    if (wr_en)
      for (int b = 0; b < MASK_W; b++)
        if (wr_mask[b]) model_mem[wr_addr][b*BYTE_W +: BYTE_W] = wr_data[b*BYTE_W +: BYTE_W];
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_mask = '0; rd_req_val = 1'b0;
  endtask

  task automatic write(input int a, input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d; wr_mask = m;
    tick();
    wr_en = 1'b0; wr_mask = '0;
  endtask

  localparam logic [DATA_W-1:0] T1_FULL = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [DATA_W-1:0] T1_AA   = {8{16'hAAAA}};
  localparam logic [DATA_W-1:0] T1_EXP  = 128'h1111_2222_3333_4444_AAAA_AAAA_AAAA_AAAA;
`ifdef RAM_1R1W_BYTE_MASK_PIPE_BYPASS_EN
  localparam logic [DATA_W-1:0] T4_EXP = 128'h0000_0000_0000_0000_0000_0000_0000_FFFF;
`else
  localparam logic [DATA_W-1:0] T4_EXP = '0;
`endif

  initial begin
    int a0, a1, r0, r1;
    for (int k = 0; k < 2; k++) begin
      acc_cnt[k] = 0; resp_cnt[k] = 0; last_resp[k] = '0;
      first_cyc[k] = -1; last_cyc[k] = -1; rdy_low_cnt[k] = 0;
    end
    tick(3);
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) write(a, init_word(a), '1);
    check("post_rst_rdy_l1", DATA_W'(rdy_o[0]), DATA_W'(1));
    check("post_rst_val_l2", DATA_W'(val_o[1]), DATA_W'(0));

    // Test 1: full write then lower-half masked write, read back.
    write(5, T1_FULL, 8'hFF);
    write(5, T1_AA, 8'h0F);
    rd_resp_rdy = 1'b1; rd_req_val = 1'b1; rd_req_addr = 6'd5;
    tick();
    idle();
    tick(4);
    check("t1_masked_l1", last_resp[0], T1_EXP);
    check("t1_masked_l2", last_resp[1], T1_EXP);

    // Test 2: backpressure fills credits, then drain in order.
    rd_resp_rdy = 1'b0;
    a0 = acc_cnt[0]; a1 = acc_cnt[1]; r0 = resp_cnt[0]; r1 = resp_cnt[1];
    for (int i = 0; i < 6; i++) begin
      rd_req_val = 1'b1; rd_req_addr = ADDR_W'(20 + i);
      tick();
    end
    idle();
    tick(2);
    check("t2_accepted_l1", DATA_W'(acc_cnt[0] - a0), DATA_W'(2));
    check("t2_accepted_l2", DATA_W'(acc_cnt[1] - a1), DATA_W'(3));
    check("t2_rdy_low_l2", DATA_W'(rdy_o[1]), DATA_W'(0));
    rd_resp_rdy = 1'b1;
    tick(6);
    check("t2_drained_l1", DATA_W'(resp_cnt[0] - r0), DATA_W'(2));
    check("t2_drained_l2", DATA_W'(resp_cnt[1] - r1), DATA_W'(3));
    check("t2_last_l1", last_resp[0], init_word(21));
    check("t2_last_l2", last_resp[1], init_word(22));

    // Test 3: 16 back-to-back reads with the consumer always ready.
    r0 = resp_cnt[0]; r1 = resp_cnt[1];
    for (int k = 0; k < 2; k++) begin first_cyc[k] = -1; rdy_low_cnt[k] = 0; end
    in_t3 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rd_req_val = 1'b1; rd_req_addr = ADDR_W'(i);
      tick();
    end
    in_t3 = 1'b0;
    idle();
    tick(5);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t3_count_l%0d", k + 1), DATA_W'(resp_cnt[k] - (k == 0 ? r0 : r1)), DATA_W'(16));
      check($sformatf("t3_span_l%0d", k + 1), DATA_W'(last_cyc[k] - first_cyc[k]), DATA_W'(15));
      check($sformatf("t3_rdy_l%0d", k + 1), DATA_W'(rdy_low_cnt[k]), DATA_W'(0));
    end
    check("t3_last_data_l2", last_resp[1], init_word(15));

    // Test 4: same-cycle write and read of one address.
    write(9, '0, '1);
    wr_en = 1'b1; wr_addr = 6'd9; wr_data = '1; wr_mask = 8'h01;
    rd_req_val = 1'b1; rd_req_addr = 6'd9;
    tick();
    idle();
    tick(4);
    check("t4_collide_l1", last_resp[0], T4_EXP);
    check("t4_collide_l2", last_resp[1], T4_EXP);

    // Test 5: reset with reads in flight discards them.
    rd_resp_rdy = 1'b0;
    rd_req_val = 1'b1; rd_req_addr = 6'd1;
    tick();
    rd_req_addr = 6'd2;
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_rdy_l1", DATA_W'(rdy_o[0]), DATA_W'(1));
    check("t5_val_l2", DATA_W'(val_o[1]), DATA_W'(0));
    r0 = resp_cnt[0]; r1 = resp_cnt[1];
    rd_resp_rdy = 1'b1;
    tick(5);
    check("t5_stale_l1", DATA_W'(resp_cnt[0] - r0), DATA_W'(0));
    check("t5_stale_l2", DATA_W'(resp_cnt[1] - r1), DATA_W'(0));

    // Test 6: random mixed traffic, checked cycle by cycle by the model.
    for (int i = 0; i < 10000; i++) begin
      wr_en       = 1'($urandom_range(0, 1));
      wr_addr     = ADDR_W'($urandom_range(0, 31));
      wr_data     = {$urandom, $urandom, $urandom, $urandom};
      wr_mask     = MASK_W'($urandom_range(0, 255));
      rd_req_val  = 1'($urandom_range(0, 1));
      rd_req_addr = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom_range(0, 31));
      rd_resp_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle();
    rd_resp_rdy = 1'b1;
    tick(8);
    check("t6_drained_l1", DATA_W'(exp_q[0].size()), DATA_W'(0));
    check("t6_drained_l2", DATA_W'(exp_q[1].size()), DATA_W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
